// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: synchronised active-low IRQ lines plus an ID-stage
// exception, fixed-priority or round-robin arbitration, and a 4-entry CSR block.
//
// state | meaning
// IDLE  | no request outstanding, arbitrating eligible sources
// REQ   | request presented to the CPU, outputs frozen until int_ack
// SERV  | handler running, waiting for eoi (RTI retired)
module lc3_int_ctrl #(
    parameter int               NCH      = 8,
    parameter int               MODE     = 0,
    parameter logic [7:0]       VEC_BASE = 8'h80,
    parameter logic [7:0]       EXC_VEC  = 8'h01,
    parameter logic [3*NCH-1:0] CH_PL    = {NCH{3'd4}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  irq,
    input  logic            exc,
    input  logic [2:0]      psr_pl,
    input  logic            int_ack,
    input  logic            eoi,
    input  logic            csr_we,
    input  logic [1:0]      csr_addr,
    input  logic [15:0]     csr_wdata,
    output logic [15:0]     csr_rdata,
    output logic            int_r,
    output logic            int_exc,
    output logic [7:0]      int_vec,
    output logic [2:0]      int_pl
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

    state_t         state, state_nxt;
    logic [NCH-1:0] sync1, sync2, prev, fall_q;
    logic [NCH-1:0] pend, pend_nxt, mask, elig, set_vec, clr_vec;
    logic           exc_pend, exc_q, any_ch, capture, ack_fire;
    logic [7:0]     vec_q;
    logic [2:0]     pl_q, win_pl;
    logic [3:0]     grant, last_grant, win;

    assign ack_fire = (state == REQ) && int_ack;

    // Round-robin scans channels above last_grant first, then wraps from 0.
    always_comb begin
        elig   = '0;
        any_ch = 1'b0;
        win    = '0;
        win_pl = '0;
        for (int i = 0; i < NCH; i++)
            elig[i] = pend[i] & mask[i] & (CH_PL[3*i +: 3] > psr_pl);
        if (MODE == 0) begin
            for (int i = 0; i < NCH; i++)
                if (elig[i]) begin
                    any_ch = 1'b1;
                    win    = 4'(i);
                    win_pl = CH_PL[3*i +: 3];
                end
        end else begin
            for (int i = 0; i < NCH; i++)
                if (!any_ch && elig[i] && (4'(i) > last_grant)) begin
                    any_ch = 1'b1;
                    win    = 4'(i);
                    win_pl = CH_PL[3*i +: 3];
                end
            for (int i = 0; i < NCH; i++)
                if (!any_ch && elig[i] && (4'(i) <= last_grant)) begin
                    any_ch = 1'b1;
                    win    = 4'(i);
                    win_pl = CH_PL[3*i +: 3];
                end
        end
    end

    // Sets are applied after clears so a coincident new edge is never lost.
    always_comb begin
        set_vec = fall_q;
        clr_vec = '0;
        if (csr_we && csr_addr == 2'd3) set_vec = set_vec | csr_wdata[NCH-1:0];
        if (csr_we && csr_addr == 2'd1) clr_vec = csr_wdata[NCH-1:0];
        for (int i = 0; i < NCH; i++)
            if (ack_fire && !exc_q && grant == 4'(i)) clr_vec[i] = 1'b1;
        pend_nxt = (pend & ~clr_vec) | set_vec;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (exc_pend || any_ch) begin
                state_nxt = REQ;
                capture   = 1'b1;
            end
            REQ:  if (int_ack) state_nxt = SERV;
            SERV: if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        int_r   = (state == REQ);
        int_exc = exc_q;
        int_vec = vec_q;
        int_pl  = pl_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sync1      <= '1;
            sync2      <= '1;
            prev       <= '1;
            fall_q     <= '0;
            pend       <= '0;
            mask       <= '0;
            exc_pend   <= 1'b0;
            exc_q      <= 1'b0;
            vec_q      <= '0;
            pl_q       <= '0;
            grant      <= '0;
            last_grant <= 4'(NCH - 1);
        end else begin
            state    <= state_nxt;
            sync1    <= irq;
            sync2    <= sync1;
            prev     <= sync2;
            fall_q   <= prev & ~sync2;
            pend     <= pend_nxt;
            exc_pend <= exc | (exc_pend & ~(ack_fire & exc_q));
            if (csr_we && csr_addr == 2'd0) mask <= csr_wdata[NCH-1:0];
            if (capture) begin
                exc_q <= exc_pend;
                vec_q <= exc_pend ? EXC_VEC : VEC_BASE + {4'b0, win};
                pl_q  <= exc_pend ? 3'd7 : win_pl;
                if (!exc_pend) grant <= win;
            end
            if (ack_fire && MODE == 1 && !exc_q) last_grant <= grant;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            2'd0:    csr_rdata[NCH-1:0] = mask;
            2'd1:    csr_rdata[NCH-1:0] = pend;
            2'd2:    csr_rdata = {9'b0, state, exc_pend, grant};
            default: csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Directed bench for lc3_int_ctrl: a fixed-priority and a round-robin instance
// share stimulus; each scenario starts from reset so both stay in lockstep.
module tb_lc3_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        exc, int_ack, eoi, csr_we;
    logic [2:0]  psr_pl;
    logic [1:0]  csr_addr;
    logic [15:0] csr_wdata;
    logic [15:0] rdata0, rdata1;
    logic        r0, r1, exc0, exc1;
    logic [7:0]  vec0, vec1;
    logic [2:0]  pl0, pl1;
    logic [15:0] rv;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    lc3_int_ctrl #(.MODE(0)) dut0 (
        .clk(clk), .reset(reset), .irq(irq), .exc(exc), .psr_pl(psr_pl),
        .int_ack(int_ack), .eoi(eoi), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(rdata0), .int_r(r0), .int_exc(exc0),
        .int_vec(vec0), .int_pl(pl0)
    );

    lc3_int_ctrl #(.MODE(1)) dut1 (
        .clk(clk), .reset(reset), .irq(irq), .exc(exc), .psr_pl(psr_pl),
        .int_ack(int_ack), .eoi(eoi), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(rdata1), .int_r(r1), .int_exc(exc1),
        .int_vec(vec1), .int_pl(pl1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        csr_addr = a;
        #1;
        d = rdata0;
    endtask

    task automatic do_reset();
        reset = 1'b0; irq = '1; exc = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        csr_we = 1'b0; csr_addr = 2'd0; csr_wdata = '0; psr_pl = 3'd0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [15:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irq = ~bits;
        tick();
        irq = '1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!r0 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, 16'(r0), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // reset state and ignored ack in IDLE
        do_reset();
        chk("rst_int_r", 16'(r0), 16'h0);
        chk("rst_vec", 16'(vec0), 16'h0);
        chk("rst_pl", 16'(pl0), 16'h0);
        rd(2'd0, rv); chk("rst_mask", rv, 16'h0);
        rd(2'd2, rv); chk("rst_status", rv, 16'h0);
        pulse_ack();
        rd(2'd2, rv); chk("ack_idle_ignored", rv, 16'h0);

        // single channel, exact latency
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        rd(2'd0, rv); chk("mask_rw", rv, 16'h00FF);
        pulse_irq(8'h08);
        tick();
        tick();
        chk("lat_e2_no_req", 16'(r0), 16'h0);
        tick();
        rd(2'd1, rv); chk("lat_e3_pend", rv, 16'h0008);
        chk("lat_e3_no_req", 16'(r0), 16'h0);
        tick();
        chk("lat_e4_req", 16'(r0), 16'h1);
        chk("ch3_vec", 16'(vec0), 16'h83);
        chk("ch3_pl", 16'(pl0), 16'h4);
        chk("ch3_exc", 16'(exc0), 16'h0);
        rd(2'd2, rv); chk("status_req", rv, 16'h0023);
        pulse_ack();
        chk("ack_drops_r", 16'(r0), 16'h0);
        rd(2'd1, rv); chk("ack_clears_pend", rv, 16'h0);
        rd(2'd2, rv); chk("status_serv", rv, 16'h0043);
        pulse_eoi();
        rd(2'd2, rv); chk("status_idle", rv, 16'h0003);

        // simultaneous channels 2 and 5
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        pulse_irq(8'h24);
        wait_req("dual_req1");
        chk("fixed_first_85", 16'(vec0), 16'h85);
        chk("rr_first_82", 16'(vec1), 16'h82);
        pulse_ack();
        pulse_eoi();
        wait_req("dual_req2");
        chk("fixed_second_82", 16'(vec0), 16'h82);
        chk("rr_second_85", 16'(vec1), 16'h85);

        // round-robin alternation on channels 1 and 6
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        csr_wr(2'd3, 16'h0042);
        for (int k = 0; k < 4; k++) begin
            wait_req("rr_req");
            chk($sformatf("rr_grant%0d", k), 16'(vec1), (k % 2 == 0) ? 16'h81 : 16'h86);
            chk($sformatf("fixed_grant%0d", k), 16'(vec0), 16'h86);
            pulse_ack();
            chk("serv_no_req", 16'(r0), 16'h0);
            csr_wr(2'd3, 16'h0042);
            pulse_eoi();
        end

        // exception beats pending channel 4
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        csr_we = 1'b1; csr_addr = 2'd3; csr_wdata = 16'h0010; exc = 1'b1;
        tick();
        csr_we = 1'b0; exc = 1'b0;
        tick();
        chk("exc_req", 16'(r0), 16'h1);
        chk("exc_flag", 16'(exc0), 16'h1);
        chk("exc_vec", 16'(vec0), 16'h01);
        chk("exc_pl", 16'(pl0), 16'h7);
        pulse_ack();
        pulse_eoi();
        tick();
        chk("after_exc_vec", 16'(vec0), 16'h84);
        chk("after_exc_flag", 16'(exc0), 16'h0);

        // priority gating, RW1C, frozen request
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        psr_pl = 3'd4;
        pulse_irq(8'h01);
        repeat (6) tick();
        chk("pl_blocked", 16'(r0), 16'h0);
        rd(2'd1, rv); chk("pl_blocked_pend", rv, 16'h0001);
        csr_wr(2'd1, 16'h0001);
        rd(2'd1, rv); chk("rw1c_clear", rv, 16'h0);
        csr_wr(2'd3, 16'h0001);
        psr_pl = 3'd3;
        tick();
        chk("pl_open_req", 16'(r0), 16'h1);
        chk("pl_open_vec", 16'(vec0), 16'h80);
        psr_pl = 3'd7;
        csr_wr(2'd0, 16'h0000);
        pulse_eoi();
        csr_wr(2'd3, 16'h0080);
        chk("frozen_r", 16'(r0), 16'h1);
        chk("frozen_vec", 16'(vec0), 16'h80);
        chk("frozen_pl", 16'(pl0), 16'h4);
        pulse_ack();
        rd(2'd1, rv); chk("pend_after_ack", rv, 16'h0080);

        // reset in the middle of a request
        do_reset();
        csr_wr(2'd0, 16'h00FF);
        csr_wr(2'd3, 16'h0004);
        tick();
        chk("pre_reset_req", 16'(r0), 16'h1);
        reset = 1'b0;
        tick();
        chk("mid_reset_r", 16'(r0), 16'h0);
        rd(2'd1, rv); chk("mid_reset_pend", rv, 16'h0);
        rd(2'd0, rv); chk("mid_reset_mask", rv, 16'h0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
